// File: rtl/pkt_write_unit.sv
// Ingress packet writer: allocates free blocks, writes words to the MMU, links the blocks, and emits one descriptor per packet.
// Optional PKT_WRITE_STATS_EN adds saturating accepted and dropped descriptor counters (oPktCnt, oDropCnt).
module pkt_write_unit #(
  parameter int unsigned ADDR_LENTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned BLOCK_WORDS = 16,
  parameter int unsigned MAX_BLOCKS  = 15
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic [DATA_WIDTH-1:0] iData,
  input  logic                  iDataVld,
  input  logic                  iDataLast,
  output logic                  oDataRdy,
  output logic                  oFreeAddrReq,
  input  logic [ADDR_LENTH-1:0] iFreeAddr,
  input  logic                  iFreeAddrVld,
  output logic [ADDR_LENTH-1:0] oLaddr,
  output logic [ADDR_LENTH-1:0] oLdata,
  output logic                  oLwrVld,
  input  logic                  iMmuRdy,
  output logic [ADDR_LENTH-1:0] oBlockAddr,
  output logic                  oMmuWriteReq,
  output logic [DATA_WIDTH-1:0] oMmuWriteData,
  output logic                  oMmuWriteLast,
  output logic [ADDR_LENTH-1:0] oPktFirAddr,
  output logic [3:0]            oPktBlockNum,
  output logic                  oPktDrop,
  output logic                  oPktFirAddrVld,
`ifdef PKT_WRITE_STATS_EN
  output logic [15:0]           oPktCnt,
  output logic [15:0]           oDropCnt,
`endif
  input  logic                  iPktFirAddrRdy
);

  localparam int unsigned WCW = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
  localparam logic [WCW-1:0] WC_LAST = WCW'(BLOCK_WORDS - 1);
  localparam logic [3:0] BLK_MAX = 4'(MAX_BLOCKS);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ALLOC   = 3'd1,
    ST_WRITE   = 3'd2,
    ST_DISCARD = 3'd3,
    ST_DESC    = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_LENTH-1:0] cur_q, cur_d;
  logic [ADDR_LENTH-1:0] prev_q, prev_d;
  logic [ADDR_LENTH-1:0] fir_q, fir_d;
  logic [3:0]            blk_q, blk_d;
  logic [WCW-1:0]        wcnt_q, wcnt_d;
  logic                  first_q, first_d;
  logic                  drop_q, drop_d;
  logic                  req_q, req_d;
  logic                  accept;

`ifdef PKT_WRITE_STATS_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;
  logic [15:0] drop_cnt_q, drop_cnt_d;
`endif

  assign accept = iDataVld & iMmuRdy;

  // State and datapath registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= ST_IDLE;
      cur_q      <= '0;
      prev_q     <= '0;
      fir_q      <= '0;
      blk_q      <= '0;
      wcnt_q     <= '0;
      first_q    <= 1'b0;
      drop_q     <= 1'b0;
      req_q      <= 1'b0;
`ifdef PKT_WRITE_STATS_EN
      pkt_cnt_q  <= '0;
      drop_cnt_q <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cur_q      <= cur_d;
      prev_q     <= prev_d;
      fir_q      <= fir_d;
      blk_q      <= blk_d;
      wcnt_q     <= wcnt_d;
      first_q    <= first_d;
      drop_q     <= drop_d;
      req_q      <= req_d;
`ifdef PKT_WRITE_STATS_EN
      pkt_cnt_q  <= pkt_cnt_d;
      drop_cnt_q <= drop_cnt_d;
`endif
    end
  end

  // Next state and datapath updates; first_q means the first block is already taken
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    prev_d  = prev_q;
    fir_d   = fir_q;
    blk_d   = blk_q;
    wcnt_d  = wcnt_q;
    first_d = first_q;
    drop_d  = drop_q;
    req_d   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (iDataVld) begin
          req_d   = 1'b1;
          blk_d   = '0;
          first_d = 1'b0;
          drop_d  = 1'b0;
          state_d = ST_ALLOC;
        end
      end
      ST_ALLOC: begin
        if (iFreeAddrVld) begin
          cur_d = iFreeAddr;
          if (!first_q) begin
            fir_d   = iFreeAddr;
            first_d = 1'b1;
          end
          blk_d   = blk_q + 4'd1;
          wcnt_d  = '0;
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (accept) begin
          wcnt_d = wcnt_q + WCW'(1);
          if (iDataLast) begin
            drop_d  = 1'b0;
            state_d = ST_DESC;
          end else if (wcnt_q == WC_LAST) begin
            if (blk_q < BLK_MAX) begin
              req_d   = 1'b1;
              prev_d  = cur_q;
              state_d = ST_ALLOC;
            end else begin
              state_d = ST_DISCARD;
            end
          end
        end
      end
      ST_DISCARD: begin
        if (iDataVld && iDataLast) begin
          drop_d  = 1'b1;
          state_d = ST_DESC;
        end
      end
      ST_DESC: begin
        if (iPktFirAddrRdy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef PKT_WRITE_STATS_EN
  // Saturating descriptor counters, bumped on acceptance
  always_comb begin
    pkt_cnt_d  = pkt_cnt_q;
    drop_cnt_d = drop_cnt_q;
    if ((state_q == ST_DESC) && iPktFirAddrRdy) begin
      if (drop_q) begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
        if (pkt_cnt_q != 16'hFFFF) pkt_cnt_d = pkt_cnt_q + 16'd1;
      end
    end
  end

  assign oPktCnt  = pkt_cnt_q;
  assign oDropCnt = drop_cnt_q;
`endif

  // Outputs; the MMU write path is a zero-latency pass-through of the ingress word
  always_comb begin
    oDataRdy       = 1'b0;
    oFreeAddrReq   = req_q;
    oLaddr         = '0;
    oLdata         = '0;
    oLwrVld        = 1'b0;
    oBlockAddr     = '0;
    oMmuWriteReq   = 1'b0;
    oMmuWriteData  = '0;
    oMmuWriteLast  = 1'b0;
    oPktFirAddr    = fir_q;
    oPktBlockNum   = blk_q;
    oPktDrop       = drop_q;
    oPktFirAddrVld = 1'b0;
    unique case (state_q)
      ST_ALLOC: begin
        if (iFreeAddrVld && first_q) begin
          oLwrVld = 1'b1;
          oLaddr  = prev_q;
          oLdata  = iFreeAddr;
        end
      end
      ST_WRITE: begin
        oDataRdy      = iMmuRdy;
        oMmuWriteReq  = accept;
        oMmuWriteData = iData;
        oBlockAddr    = cur_q;
        oMmuWriteLast = iDataLast | (wcnt_q == WC_LAST);
      end
      ST_DISCARD: oDataRdy = 1'b1;
      ST_DESC:    oPktFirAddrVld = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pkt_write_unit.sv
// Bench for pkt_write_unit: directed vector table, reset-mid-packet sequence and randomized packets
// checked against a packet-level model (block split, link pairs, descriptor).
module tb_pkt_write_unit;

  localparam int BW   = 16;
  localparam int MAXB = 15;

  logic        iClk, iRst;
  logic [31:0] iData;
  logic        iDataVld, iDataLast, oDataRdy, oFreeAddrReq;
  logic [11:0] iFreeAddr;
  logic        iFreeAddrVld;
  logic [11:0] oLaddr, oLdata;
  logic        oLwrVld, iMmuRdy;
  logic [11:0] oBlockAddr;
  logic        oMmuWriteReq;
  logic [31:0] oMmuWriteData;
  logic        oMmuWriteLast;
  logic [11:0] oPktFirAddr;
  logic [3:0]  oPktBlockNum;
  logic        oPktDrop, oPktFirAddrVld, iPktFirAddrRdy;
`ifdef PKT_WRITE_STATS_EN
  logic [15:0] oPktCnt, oDropCnt;
`endif

  pkt_write_unit dut (
    .iClk(iClk), .iRst(iRst),
    .iData(iData), .iDataVld(iDataVld), .iDataLast(iDataLast), .oDataRdy(oDataRdy),
    .oFreeAddrReq(oFreeAddrReq), .iFreeAddr(iFreeAddr), .iFreeAddrVld(iFreeAddrVld),
    .oLaddr(oLaddr), .oLdata(oLdata), .oLwrVld(oLwrVld),
    .iMmuRdy(iMmuRdy), .oBlockAddr(oBlockAddr), .oMmuWriteReq(oMmuWriteReq),
    .oMmuWriteData(oMmuWriteData), .oMmuWriteLast(oMmuWriteLast),
    .oPktFirAddr(oPktFirAddr), .oPktBlockNum(oPktBlockNum), .oPktDrop(oPktDrop),
    .oPktFirAddrVld(oPktFirAddrVld),
`ifdef PKT_WRITE_STATS_EN
    .oPktCnt(oPktCnt), .oDropCnt(oDropCnt),
`endif
    .iPktFirAddrRdy(iPktFirAddrRdy)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Environment state for the packet in flight
  int          cyc, L, idx, mmu_mode, lat, dd, gnt_wait, req_cnt, consumed;
  int          last_acc_cyc, desc_first_cyc, desc_seen, exp_nb;
  bit          noise, rand_addr, done, exp_drop;
  logic [11:0] next_addr;
  logic [31:0] words[$];
  logic [11:0] grants[$];
  logic [11:0] w_addr[$];
  logic [31:0] w_data[$];
  bit          w_last[$];
  int          w_lwr[$];
  logic [11:0] l_addr[$];
  logic [11:0] l_data[$];
  logic [3:0]  d_num;
  logic        d_drop;

  function automatic logic [127:0] all_outs();
    return 128'({oDataRdy, oFreeAddrReq, oLaddr, oLdata, oLwrVld, oBlockAddr, oMmuWriteReq,
                 oMmuWriteData, oMmuWriteLast, oPktFirAddr, oPktBlockNum, oPktDrop, oPktFirAddrVld});
  endfunction

  function automatic logic [12:0] grant_at(input int k);
    if (k < grants.size()) return {1'b1, grants[k]};
    return 13'h0;
  endfunction

  task automatic idle_inputs();
    iData = '0; iDataVld = 1'b0; iDataLast = 1'b0; iFreeAddr = '0;
    iFreeAddrVld = 1'b0; iMmuRdy = 1'b0; iPktFirAddrRdy = 1'b0;
  endtask

  // One clock: drive at negedge, observe 1 ns later (what the next posedge will act on)
  task automatic cycle();
    @(negedge iClk);
    cyc++;
    if (idx < L) begin
      iDataVld  = noise ? ($urandom_range(0, 3) != 0) : 1'b1;
      iData     = words[idx];
      iDataLast = (idx == L - 1);
    end else begin
      iDataVld  = 1'b0;
      iData     = noise ? $urandom : 32'h0;
      iDataLast = 1'b0;
    end
    case (mmu_mode)
      0:       iMmuRdy = 1'b1;
      1:       iMmuRdy = cyc[0];
      default: iMmuRdy = 1'($urandom_range(0, 1));
    endcase
    iFreeAddrVld = 1'b0;
    iFreeAddr    = '0;
    if (gnt_wait > 0) begin
      gnt_wait--;
      if (gnt_wait == 0) begin
        iFreeAddrVld = 1'b1;
        iFreeAddr    = next_addr;
        grants.push_back(next_addr);
        next_addr = rand_addr ? 12'($urandom) : next_addr + 12'd1;
      end
    end else if (noise && !oFreeAddrReq && $urandom_range(0, 7) == 0) begin
      iFreeAddrVld = 1'b1;
      iFreeAddr    = 12'($urandom);
    end
    if (oPktFirAddrVld) iPktFirAddrRdy = (desc_seen >= dd);
    else iPktFirAddrRdy = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    #1;
    if (oFreeAddrReq) begin
      req_cnt++;
      gnt_wait = (lat < 0) ? $urandom_range(1, 3) : lat;
    end
    if (oLwrVld) begin
      l_addr.push_back(oLaddr);
      l_data.push_back(oLdata);
    end
    if (oMmuWriteReq) begin
      w_addr.push_back(oBlockAddr);
      w_data.push_back(oMmuWriteData);
      w_last.push_back(oMmuWriteLast);
      w_lwr.push_back(l_addr.size());
    end
    if (iDataVld && oDataRdy) begin
      consumed++;
      idx++;
      if (iDataLast) last_acc_cyc = cyc;
    end
    if (oPktFirAddrVld) begin
      if (desc_seen == 0) begin
        desc_first_cyc = cyc;
        d_num  = oPktBlockNum;
        d_drop = oPktDrop;
      end
      chk("desc_hold_fir", 128'({1'b1, oPktFirAddr}), 128'(grant_at(0)));
      chk("desc_hold_num", 128'(oPktBlockNum), 128'(exp_nb));
      chk("desc_hold_drop", 128'(oPktDrop), 128'(exp_drop));
      desc_seen++;
      if (iPktFirAddrRdy) done = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge iClk);
    iRst = 1'b1;
    idle_inputs();
    repeat (2) @(negedge iClk);
    iRst = 1'b0;
  endtask

  // Runs one packet; abort_at >= 0 stops once that many words were accepted
  task automatic run_packet(input int len, input int mm, input int lt, input int dly,
                            input bit nz, input bit ra, input logic [11:0] base,
                            input int abort_at, output logic [3:0] got_num, output logic got_drop);
    int needed, exp_wr, n, budget, blk;
    logic [11:0] ea;
    L = len; idx = 0; mmu_mode = mm; lat = lt; dd = dly; noise = nz; rand_addr = ra;
    next_addr = base; gnt_wait = 0; req_cnt = 0; consumed = 0; done = 1'b0;
    last_acc_cyc = -10; desc_first_cyc = -20; desc_seen = 0; d_num = 'x; d_drop = 1'bx;
    words.delete(); grants.delete(); w_addr.delete(); w_data.delete(); w_last.delete();
    w_lwr.delete(); l_addr.delete(); l_data.delete();
    for (int i = 0; i < len; i++) words.push_back($urandom);
    // Packet-level model
    needed   = (len + BW - 1) / BW;
    exp_nb   = (needed > MAXB) ? MAXB : needed;
    exp_drop = (needed > MAXB);
    exp_wr   = (len > MAXB * BW) ? MAXB * BW : len;
    budget   = 8 * len + 200;
    n = 0;
    while (!done && n < budget) begin
      cycle();
      n++;
      if (abort_at >= 0 && idx >= abort_at) begin
        got_num = d_num; got_drop = d_drop;
        return;
      end
    end
    chk("pkt_completed", 128'(done), 128'(1));
    chk("words_consumed", 128'(consumed), 128'(len));
    chk("mmu_write_count", 128'(w_addr.size()), 128'(exp_wr));
    chk("addr_req_count", 128'(req_cnt), 128'(exp_nb));
    chk("link_write_count", 128'(l_addr.size()), 128'(exp_nb - 1));
    for (int i = 0; i < w_addr.size() && i < exp_wr; i++) begin
      blk = i / BW;
      ea  = grant_at(blk)[11:0];
      chk($sformatf("mmu_word[%0d]", i),
          128'({w_addr[i], w_data[i], w_last[i], 8'(w_lwr[i])}),
          128'({ea, words[i], ((i % BW) == BW - 1) || (i == len - 1), 8'(blk)}));
    end
    for (int k = 1; k < exp_nb && k <= l_addr.size(); k++)
      chk($sformatf("link_pair[%0d]", k), 128'({l_addr[k-1], l_data[k-1]}),
          128'({grant_at(k-1)[11:0], grant_at(k)[11:0]}));
    chk("desc_latency", 128'(desc_first_cyc - last_acc_cyc), 128'(1));
    chk("desc_dwell", 128'(desc_seen), 128'(dd + 1));
    got_num = d_num; got_drop = d_drop;
    if (!done) do_reset();
  endtask

  typedef struct {
    int          len;
    int          mm;
    int          lt;
    int          dly;
    logic [11:0] base;
    logic [3:0]  exp_num;
    logic        exp_drop;
  } vec_t;

  vec_t        vecs[9];
  logic [3:0]  gnum;
  logic        gdrop;

  initial begin
    iRst = 1'b1;
    idle_inputs();
    cyc = 0; L = 0; idx = 0; mmu_mode = 0; lat = 1; dd = 0; noise = 1'b0; gnt_wait = 0;
    desc_seen = 0; exp_nb = 0; exp_drop = 1'b0;
    vecs[0] = '{5,   0, 1, 0, 12'h010, 4'd1,  1'b0};
    vecs[1] = '{16,  0, 1, 0, 12'h100, 4'd1,  1'b0};
    vecs[2] = '{40,  0, 1, 0, 12'h020, 4'd3,  1'b0};
    vecs[3] = '{260, 0, 1, 0, 12'h200, 4'd15, 1'b1};
    vecs[4] = '{24,  1, 2, 5, 12'h300, 4'd2,  1'b0};
    vecs[5] = '{17,  0, 3, 0, 12'h400, 4'd2,  1'b0};
    vecs[6] = '{240, 2, 1, 1, 12'h500, 4'd15, 1'b0};
    vecs[7] = '{241, 0, 1, 0, 12'h600, 4'd15, 1'b1};
    vecs[8] = '{1,   1, 1, 2, 12'hFFE, 4'd1,  1'b0};

    repeat (3) @(negedge iClk);
    iRst = 1'b0;
    @(negedge iClk);
    #1;
    chk("reset_outputs", all_outs(), 128'(0));

    foreach (vecs[v]) begin
      run_packet(vecs[v].len, vecs[v].mm, vecs[v].lt, vecs[v].dly, 1'b0, 1'b0,
                 vecs[v].base, -1, gnum, gdrop);
      chk($sformatf("vec%0d_block_num", v), 128'(gnum), 128'(vecs[v].exp_num));
      chk($sformatf("vec%0d_drop", v), 128'(gdrop), 128'(vecs[v].exp_drop));
    end

    for (int r = 0; r < 25; r++)
      run_packet($urandom_range(1, 270), $urandom_range(0, 2), -1, $urandom_range(0, 3),
                 1'b1, 1'b1, 12'($urandom), -1, gnum, gdrop);

    // Reset while word 7 of a packet is being presented
    run_packet(20, 0, 1, 0, 1'b0, 1'b0, 12'h0A0, 6, gnum, gdrop);
    @(negedge iClk);
    iRst = 1'b1; iDataVld = 1'b1; iData = words[6]; iDataLast = 1'b0; iMmuRdy = 1'b1;
    @(negedge iClk);
    iRst = 1'b0;
    idle_inputs();
    #1;
    chk("midpkt_reset_outputs", all_outs(), 128'(0));
`ifdef PKT_WRITE_STATS_EN
    chk("midpkt_reset_stats", 128'({oPktCnt, oDropCnt}), 128'(0));
`endif
    run_packet(3, 0, 1, 0, 1'b0, 1'b0, 12'h0B0, -1, gnum, gdrop);
    chk("after_reset_num", 128'(gnum), 128'(1));
    chk("after_reset_drop", 128'(gdrop), 128'(0));
`ifdef PKT_WRITE_STATS_EN
    @(negedge iClk);
    #1;
    chk("stats_pkt_cnt", 128'(oPktCnt), 128'(1));
    chk("stats_drop_cnt", 128'(oDropCnt), 128'(0));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pkt_write_unit.md
# pkt_write_unit

Write-side counterpart of the per-port packet read path. It accepts one ingress packet stream and allocates free block addresses from AddrCtrl. It writes the packet into MMU blocks of `BLOCK_WORDS` words each, stitches the blocks into the linked-list SRAM, and emits one packet descriptor to the WRR/queue side. The descriptor carries the first address, the block count and a drop flag, which is exactly what the read unit consumes. Packets longer than `MAX_BLOCKS` blocks are truncated and flagged for drop, so the read path's drop mechanism recycles their addresses.

## Interface
Parameters:
- `ADDR_LENTH`, 12, block address width
- `DATA_WIDTH`, 32, data word width
- `BLOCK_WORDS`, 16, words per block (power of two, ≥2)
- `MAX_BLOCKS`, 15, maximum blocks per packet (≤15, fits `oPktBlockNum`)

Ports:
- `iClk`  in  1  sole clock
- `iRst`  in  1  reset: synchronous, active-high
- `iData`  in  DATA_WIDTH  ingress word
- `iDataVld`  in  1  ingress word valid
- `iDataLast`  in  1  last word of packet
- `oDataRdy`  out  1  ingress ready
- `oFreeAddrReq`  out  1  one-cycle pulse requesting a free block address
- `iFreeAddr`  in  ADDR_LENTH  granted address
- `iFreeAddrVld`  in  1  grant strobe (arrives ≥1 cycle after the request)
- `oLaddr`  out  ADDR_LENTH  linked-list write address (previous block)
- `oLdata`  out  ADDR_LENTH  linked-list write data (next block)
- `oLwrVld`  out  1  linked-list write strobe
- `iMmuRdy`  in  1  MMU can accept a write word
- `oBlockAddr`  out  ADDR_LENTH  current block address
- `oMmuWriteReq`  out  1  MMU write word valid
- `oMmuWriteData`  out  DATA_WIDTH  MMU write word
- `oMmuWriteLast`  out  1  last word written to this block
- `oPktFirAddr`  out  ADDR_LENTH  descriptor: first block address
- `oPktBlockNum`  out  4  descriptor: blocks used (1..MAX_BLOCKS)
- `oPktDrop`  out  1  descriptor: packet must be dropped by the reader
- `oPktFirAddrVld`  out  1  descriptor valid
- `iPktFirAddrRdy`  in  1  descriptor accepted

## Operation
- **FSM states:** IDLE, ALLOC, WRITE, DISCARD, DESC.
- **IDLE:**
  - `oDataRdy`=0.
  - On `iDataVld`: pulse `oFreeAddrReq`, clear the block count and the first flag, go to ALLOC.
- **ALLOC:** `oDataRdy`=0; wait for `iFreeAddrVld`. On grant:
  - Latch `iFreeAddr` into the current-block register.
  - If this is the first block, also latch it into `oPktFirAddr`.
  - Otherwise pulse `oLwrVld` for one cycle with `oLaddr`=previous block and `oLdata`=granted address.
  - Increment the block count, clear the word counter, go to WRITE.
- **WRITE:**
  - `oDataRdy` = `iMmuRdy` (combinational).
  - `oMmuWriteReq` = `iDataVld` & `iMmuRdy`.
  - `oMmuWriteData` = `iData`.
  - `oBlockAddr` = current block.
  - `oMmuWriteLast` = `iDataLast` | (word counter == BLOCK_WORDS-1).
  - On each accepted word the word counter increments. Transitions:
    - `iDataLast` accepted: go to DESC with drop=0.
    - Counter wraps (block full), not last, block count < MAX_BLOCKS: pulse `oFreeAddrReq`, save the current block as previous, go to ALLOC.
    - Counter wraps, not last, block count == MAX_BLOCKS: go to DISCARD.
    - Last word coinciding with the wrap: DESC wins. No extra allocation is made.
- **DISCARD:** `oDataRdy`=1, no MMU writes. Consume words until `iDataLast`, then go to DESC with drop=1.
- **DESC:**
  - `oPktFirAddrVld`=1; `oPktFirAddr`, `oPktBlockNum` and `oPktDrop` are held stable.
  - On `iPktFirAddrRdy`, go to IDLE.
- **Arithmetic:**
  - The word counter is $clog2(BLOCK_WORDS) bits and wraps naturally.
  - The block count is 4 bits and never exceeds MAX_BLOCKS.
- **Reset:** `iRst` mid-packet returns the FSM to IDLE and discards all partial state. Allocated addresses are not recycled; the system resets AddrCtrl together with this block.

## Timing
- **Reset values:** all outputs are 0 (the FSM is in IDLE).
- **Allocation latency:**
  - `oFreeAddrReq` is asserted in the cycle the FSM enters ALLOC.
  - The first word can be accepted the cycle after `iFreeAddrVld`.
- **Write path:** MMU write outputs are combinational pass-through of the ingress word. There are 0 cycles of latency and no buffering.
- **Throughput:** one word per cycle within a block. Block boundaries cost at least 2 cycles: the ALLOC cycle plus the grant latency.
- **Linked-list write:** issued exactly once per non-first block, in the grant cycle. It precedes the first MMU word of that block.
- **Descriptor:** asserted the cycle after the last word is accepted. It is held until accepted. The next packet is not accepted before the FSM returns to IDLE.
- **Ignored inputs:** `iFreeAddrVld` outside ALLOC and `iPktFirAddrRdy` outside DESC are ignored.

## Configuration
- `PKT_WRITE_STATS_EN` defined: adds two ports.
  - `oPktCnt` (out, 16): counts descriptors accepted with drop=0.
  - `oDropCnt` (out, 16): counts descriptors accepted with drop=1.
  - Both saturate at 0xFFFF and are cleared by `iRst`.
- Not defined: neither port nor counter exists; all other behaviour is identical.

## Test plan
- **Single 5-word packet, grant 0x010 after 1 cycle, MMU always ready:**
  - Five MMU writes to 0x010; `oMmuWriteLast` on word 5.
  - No `oLwrVld`.
  - Descriptor {0x010, 1, drop=0}.
- **Exactly 16-word packet:**
  - One block; last word coincides with the wrap.
  - Exactly one `oFreeAddrReq`; descriptor {addr, 1, 0}.
- **40-word packet, grants 0x020, 0x021, 0x022:**
  - `oLwrVld` (0x020→0x021), then (0x021→0x022).
  - 16+16+8 MMU words with `oMmuWriteLast` on words 16, 32, 40.
  - Descriptor {0x020, 3, 0}.
- **260-word packet:**
  - 15 blocks written (240 words); 20 words discarded with `oDataRdy`=1.
  - Descriptor {first, 15, drop=1}.
- **Backpressure:**
  - `iMmuRdy` toggled every cycle and `iPktFirAddrRdy` held low for 5 cycles.
  - No word lost or duplicated; descriptor stable for all 5 cycles.
- **Reset mid-packet:**
  - `iRst` pulsed during WRITE of word 7: all outputs 0 next cycle.
  - A following 3-word packet completes normally (with `PKT_WRITE_STATS_EN`: `oPktCnt`=1).
